control_sequencer: RTL

- Hardwired control unit that drives the Datapath control inputs from the latched instruction (IR) and the CON flip-flop result.
- Sequences a 3-step fetch (T0–T2) followed by an opcode-dependent execute (T3–T7), then returns to T0.
- Sits beside Datapath; every output connects 1:1 to the same-named Datapath input.

---
 rtl/control_sequencer.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/execute control unit for the Datapath
//
// Ports:
//   clk, clr (async active-low)          clock and reset
//   IR[31:0], con_out, stop              latched instruction, branch condition, halt request
//   *_out                                bus source selects (at most one active)
//   *_enable                             register load enables
//   IncPC, Read, con_in, Gra, Grb, Grc,
//   R_in, R_out, BA_out                  datapath controls
//   opcode[4:0]                          ALU operation
//   run, illegal                         executing flag, unsupported-opcode pulse
module control_sequencer #(
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        con_out,
    input  logic        stop,
    output logic        PC_out,
    output logic        ZHigh_out,
    output logic        ZLow_out,
    output logic        HI_out,
    output logic        LO_out,
    output logic        In_port_out,
    output logic        C_out,
    output logic        MDR_out,
    output logic        MDR_enable,
    output logic        MAR_enable,
    output logic        Z_enable,
    output logic        Y_enable,
    output logic        PC_enable,
    output logic        LO_enable,
    output logic        HI_enable,
    output logic        IR_enable,
    output logic        out_port_enable,
    output logic        RAM_write_enable,
    output logic        IncPC,
    output logic        Read,
    output logic        con_in,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        R_in,
    output logic        R_out,
    output logic        BA_out,
    output logic [4:0]  opcode,
    output logic        run,
    output logic        illegal
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_IN   = 5'b10101;
    localparam logic [4:0] OP_OUT  = 5'b10110;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     state, next_state;
    state_t     end_state;
    logic [4:0] ir_op;
    logic       unused_ir_bits;

    assign ir_op          = IR[31:27];
    assign unused_ir_bits = ^IR[26:0];

    // Every path back to T0 goes through here so a pending stop is honoured
    // only at an instruction boundary.
    assign end_state = stop ? S_HALT : S_T0;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state       = state;
        PC_out           = 1'b0;
        ZHigh_out        = 1'b0;
        ZLow_out         = 1'b0;
        HI_out           = 1'b0;
        LO_out           = 1'b0;
        In_port_out      = 1'b0;
        C_out            = 1'b0;
        MDR_out          = 1'b0;
        MDR_enable       = 1'b0;
        MAR_enable       = 1'b0;
        Z_enable         = 1'b0;
        Y_enable         = 1'b0;
        PC_enable        = 1'b0;
        LO_enable        = 1'b0;
        HI_enable        = 1'b0;
        IR_enable        = 1'b0;
        out_port_enable  = 1'b0;
        RAM_write_enable = 1'b0;
        IncPC            = 1'b0;
        Read             = 1'b0;
        con_in           = 1'b0;
        Gra              = 1'b0;
        Grb              = 1'b0;
        Grc              = 1'b0;
        R_in             = 1'b0;
        R_out            = 1'b0;
        BA_out           = 1'b0;
        opcode           = 5'b00000;
        run              = 1'b0;
        illegal          = 1'b0;

        // RESET and HALT keep every output at zero, opcode included.
        if (state != S_RESET && state != S_HALT) begin
            run    = 1'b1;
            opcode = ir_op;
        end

        case (state)
            S_RESET: next_state = end_state;
            S_T0: begin
                PC_out     = 1'b1;
                MAR_enable = 1'b1;
                IncPC      = 1'b1;
                next_state = S_T1;
            end
            S_T1: begin
                Read       = 1'b1;
                MDR_enable = 1'b1;
                next_state = S_T2;
            end
            S_T2: begin
                MDR_out    = 1'b1;
                IR_enable  = 1'b1;
                next_state = S_T3;
            end
            S_T3: begin
                case (ir_op)
                    OP_LD, OP_LDI, OP_ST: begin
                        Grb = 1'b1; BA_out = 1'b1; Y_enable = 1'b1;
                        next_state = S_T4;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                        Grb = 1'b1; R_out = 1'b1; Y_enable = 1'b1;
                        next_state = S_T4;
                    end
                    OP_BR: begin
                        Gra = 1'b1; R_out = 1'b1; con_in = 1'b1;
                        next_state = S_T4;
                    end
                    OP_JR: begin
                        Gra = 1'b1; R_out = 1'b1; PC_enable = 1'b1;
                        next_state = end_state;
                    end
                    OP_IN: begin
                        In_port_out = 1'b1; Gra = 1'b1; R_in = 1'b1;
                        next_state = end_state;
                    end
                    OP_OUT: begin
                        Gra = 1'b1; R_out = 1'b1; out_port_enable = 1'b1;
                        next_state = end_state;
                    end
                    OP_NOP:  next_state = end_state;
                    OP_HALT: next_state = S_HALT;
                    default: begin
                        illegal    = 1'b1;
                        next_state = end_state;
                    end
                endcase
            end
            S_T4: begin
                next_state = S_T5;
                case (ir_op)
                    OP_LD, OP_LDI, OP_ST: begin
                        C_out = 1'b1; Z_enable = 1'b1; opcode = ADD_OP;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        Grc = 1'b1; R_out = 1'b1; Z_enable = 1'b1;
                    end
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        C_out = 1'b1; Z_enable = 1'b1;
                    end
                    OP_BR: begin
                        PC_out = 1'b1; Y_enable = 1'b1;
                    end
                    default: next_state = end_state;
                endcase
            end
            S_T5: begin
                case (ir_op)
                    OP_LD, OP_ST: begin
                        ZLow_out = 1'b1; MAR_enable = 1'b1;
                        next_state = S_T6;
                    end
                    OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
                        ZLow_out = 1'b1; Gra = 1'b1; R_in = 1'b1;
                        next_state = end_state;
                    end
                    OP_BR: begin
                        C_out = 1'b1; Z_enable = 1'b1; opcode = ADD_OP;
                        next_state = S_T6;
                    end
                    default: next_state = end_state;
                endcase
            end
            S_T6: begin
                case (ir_op)
                    OP_LD: begin
                        Read = 1'b1; MDR_enable = 1'b1;
                        next_state = S_T7;
                    end
                    // MDR loads from the register bus here, so Read stays low.
                    OP_ST: begin
                        Gra = 1'b1; R_out = 1'b1; MDR_enable = 1'b1;
                        next_state = S_T7;
                    end
                    OP_BR: begin
                        ZLow_out   = 1'b1;
                        PC_enable  = con_out;
                        next_state = end_state;
                    end
                    default: next_state = end_state;
                endcase
            end
            S_T7: begin
                next_state = end_state;
                case (ir_op)
                    OP_LD: begin
                        MDR_out = 1'b1; Gra = 1'b1; R_in = 1'b1;
                    end
                    OP_ST:   RAM_write_enable = 1'b1;
                    default: ;
                endcase
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_RESET;
        endcase
    end

endmodule
